ssd_scan: RTL



---
 rtl/ssd_pkg.sv | 40 ++++
 rtl/ssd_decode.sv | 25 ++
 rtl/ssd_scan.sv | 107 ++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared types and constants for the 7-segment scan stage.
// Character codes come from the scrolling-text shift register; segment
// patterns are active-low {a,b,c,d,e,f,g,dp} with dp always off.
package ssd_pkg;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned SEG_W  = 8;
    localparam int unsigned DIG_N  = 4;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [SEG_W-1:0]  seg_t;
    typedef logic [DIG_N-1:0]  an_t;
    typedef logic [1:0]        dig_idx_t;

    // Character codes understood by the decoder
    localparam code_t CH_E     = 4'd0;
    localparam code_t CH_H     = 4'd1;
    localparam code_t CH_N     = 4'd2;
    localparam code_t CH_T     = 4'd3;
    localparam code_t CH_U     = 4'd4;
    localparam code_t CH_C     = 4'd5;
    localparam code_t CH_S     = 4'd6;
    localparam code_t CH_BLANK = 4'd7;

    // Active-low segment patterns, bit 0 is dp (kept at 1 = off)
    localparam seg_t SEG_E     = 8'h61;
    localparam seg_t SEG_H     = 8'h91;
    localparam seg_t SEG_N     = 8'hD5;
    localparam seg_t SEG_T     = 8'hE1;
    localparam seg_t SEG_U     = 8'h83;
    localparam seg_t SEG_C     = 8'h63;
    localparam seg_t SEG_S     = 8'h49;
    localparam seg_t SEG_BLANK = 8'hFF;

    // Active-low anode enable for one digit position
    function automatic an_t an_select(input dig_idx_t idx);
        return ~(an_t'(1) << idx);
    endfunction

endpackage

// File: rtl/ssd_decode.sv
// ssd_decode: character code to active-low 7-segment pattern.
// Purely combinational; codes outside the defined set render blank.
module ssd_decode
    import ssd_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] seg
);

    // Map each known code to its glyph, everything else dark
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            CH_E:    seg = SEG_E;
            CH_H:    seg = SEG_H;
            CH_N:    seg = SEG_N;
            CH_T:    seg = SEG_T;
            CH_U:    seg = SEG_U;
            CH_C:    seg = SEG_C;
            CH_S:    seg = SEG_S;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ssd_scan.sv
// ssd_scan: time-multiplexed driver for a 4-digit common-anode display.
// A prescaler produces one tick every TICK_CNT clocks, advancing a 2-bit
// digit index; anode/segment outputs are registered from the current
// index and the live character inputs (1 clk latency).
// Optional build macro SSD_LAMP_TEST_EN adds a lamp_test input that
// lights every segment of every digit while the scan keeps running.
module ssd_scan
    import ssd_pkg::*;
#(
    parameter int unsigned TICK_CNT = 100000,
    parameter int unsigned CNT_W    = 20
) (
    input  logic       clk,
    input  logic       rst,
`ifdef SSD_LAMP_TEST_EN
    input  logic       lamp_test,
`endif
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    output logic [3:0] ssd_an,
    output logic [7:0] ssd_seg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    dig_idx_t         idx_q, idx_d;
    logic             tick;
    code_t            code_sel;
    seg_t             seg_dec;
    an_t              an_q, an_d;
    seg_t             seg_q, seg_d;

    assign tick = (cnt_q == CNT_LAST);

    // Prescaler next state: count 0..TICK_CNT-1 and wrap
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
            cnt_d = '0;
        end
    end

    // Digit index next state: advance once per tick, wrapping 3->0
    always_comb begin
        idx_d = idx_q;
        if (tick) begin
            idx_d = idx_q + 2'd1;
        end
    end

    // Prescaler and digit index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Select the character for the currently active digit
    always_comb begin
        code_sel = in0;
        case (idx_q)
            2'd0:    code_sel = in0;
            2'd1:    code_sel = in1;
            2'd2:    code_sel = in2;
            default: code_sel = in3;
        endcase
    end

    ssd_decode u_decode (
        .code (code_sel),
        .seg  (seg_dec)
    );

    // Output register next state: normal scan, or all-lit in lamp test
    always_comb begin
        an_d  = an_select(idx_q);
        seg_d = seg_dec;
`ifdef SSD_LAMP_TEST_EN
        if (lamp_test) begin
            an_d  = '0;
            seg_d = '0;
        end
`endif
    end

    // Output register: dark during reset, otherwise reload every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= '1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign ssd_an  = an_q;
    assign ssd_seg = seg_q;

endmodule
